// File: rtl/sisc_pkg.sv
// sisc_pkg: opcode, state and ALU override constants shared by the sisc control unit
package sisc_pkg;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ALU = 4'd1;
    localparam logic [3:0] OP_LOD = 4'd2;
    localparam logic [3:0] OP_STR = 4'd3;
    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_BNR = 4'd7;
    localparam logic [3:0] OP_HLT = 4'd15;
    localparam logic [1:0] ALU_OP_NOSTAT = 2'b10;
    localparam logic [1:0] ALU_OP_ADDR = 2'b11;
    typedef enum logic [2:0] {
        S_START0, S_START1, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_e;
endpackage

// File: rtl/sisc_br_eval.sv
// sisc_br_eval: branch-taken and absolute-target decode against the status flags
module sisc_br_eval
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken,
    output logic       br_sel
);
    logic w_hit;
    assign w_hit = |(mm & stat);
    always_comb begin
        taken = (opcode == OP_BRA || opcode == OP_BRR) ? w_hit :
                (opcode == OP_BNE || opcode == OP_BNR) ? !w_hit : 1'b0;
        br_sel = opcode == OP_BRA || opcode == OP_BNE;
    end
endmodule

// File: rtl/sisc_ctrl.sv
// sisc_ctrl: multicycle fetch/decode/execute/mem/writeback sequencer with retired counter
module sisc_ctrl
    import sisc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [3:0]       opcode,
    input  logic [3:0]       mm,
    input  logic [3:0]       stat,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             rb_sel,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic             pc_rst,
    output logic             mm_sel,
    output logic             dm_we,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    state_e r_state, w_next;
    logic [CNT_W-1:0] r_retired;
    logic w_taken, w_abs, w_retire, w_is_str, w_is_lod, w_is_alu;
    sisc_br_eval u_br (.opcode(opcode), .mm(mm), .stat(stat), .taken(w_taken), .br_sel(w_abs));
    assign w_is_str = opcode == OP_STR;
    assign w_is_lod = opcode == OP_LOD;
    assign w_is_alu = opcode == OP_ALU;
    assign retired = r_retired;
    always_comb begin
        w_next = r_state;
        alu_op = ALU_OP_NOSTAT;
        rf_we = 1'b0;
        wb_sel = 1'b0;
        rb_sel = 1'b0;
        ir_load = 1'b0;
        pc_write = 1'b0;
        pc_sel = 1'b0;
        br_sel = 1'b0;
        pc_rst = 1'b0;
        mm_sel = 1'b0;
        dm_we = 1'b0;
        halted = 1'b0;
        case (r_state)
            S_START0: begin
                pc_rst = 1'b1;
                w_next = S_START1;
            end
            S_START1: w_next = S_FETCH;
            S_FETCH: begin
                ir_load = 1'b1;
                pc_write = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                pc_write = w_taken;
                pc_sel = w_taken;
                br_sel = w_taken & w_abs;
                rb_sel = w_is_str;
                w_next = opcode == OP_HLT ? S_HALT :
                         (w_is_alu || w_is_lod || w_is_str) ? S_EXECUTE : S_FETCH;
            end
            S_EXECUTE: begin
                alu_op = w_is_alu ? {1'b0, mm[3]} : ALU_OP_ADDR;
                rb_sel = w_is_str;
                w_next = w_is_alu ? S_WRITEBACK : (w_is_lod || w_is_str) ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                alu_op = ALU_OP_ADDR;
                mm_sel = 1'b1;
                dm_we = w_is_str;
                rb_sel = w_is_str;
                w_next = w_is_lod ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                rf_we = 1'b1;
                wb_sel = w_is_lod;
                mm_sel = w_is_lod;
                // ALU results re-present the EXECUTE override so the status re-latch is harmless
                alu_op = w_is_lod ? ALU_OP_ADDR : {1'b0, mm[3]};
                w_next = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_START0;
        endcase
    end
    assign w_retire = w_next == S_FETCH &&
                      (r_state == S_DECODE || r_state == S_MEM || r_state == S_WRITEBACK);
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= S_START0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire && r_retired != {CNT_W{1'b1}}) r_retired <= r_retired + 1'b1;
        end
    end
endmodule

// File: tb/tb_sisc_ctrl.sv
// tb_sisc_ctrl: scripted per-instruction output model checked against two counter widths
module tb_sisc_ctrl;
    logic clk = 1'b0;
    logic rst_f = 1'b0;
    logic [3:0] opcode = 4'd0, mm = 4'd0, stat = 4'd0;
    logic [12:0] v16, v4;
    logic [15:0] r16;
    logic [3:0] r4;
    int checks = 0, errors = 0, cnt = 0, nst = 0;
    logic [12:0] last_dec, last_exec;
    int last_cyc;
    localparam logic [12:0] RF = 13'h400, WB = 13'h200, RB = 13'h100, IR = 13'h080,
        PW = 13'h040, PS = 13'h020, BS = 13'h010, PR = 13'h008, MS = 13'h004,
        DW = 13'h002, HL = 13'h001;
    always #5 clk = ~clk;
    sisc_ctrl #(.CNT_W(16)) u16 (.clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .alu_op(v16[12:11]), .rf_we(v16[10]), .wb_sel(v16[9]), .rb_sel(v16[8]), .ir_load(v16[7]),
        .pc_write(v16[6]), .pc_sel(v16[5]), .br_sel(v16[4]), .pc_rst(v16[3]), .mm_sel(v16[2]),
        .dm_we(v16[1]), .halted(v16[0]), .retired(r16));
    sisc_ctrl #(.CNT_W(4)) u4 (.clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .alu_op(v4[12:11]), .rf_we(v4[10]), .wb_sel(v4[9]), .rb_sel(v4[8]), .ir_load(v4[7]),
        .pc_write(v4[6]), .pc_sel(v4[5]), .br_sel(v4[4]), .pc_rst(v4[3]), .mm_sel(v4[2]),
        .dm_we(v4[1]), .halted(v4[0]), .retired(r4));
    function automatic logic [12:0] ao(input logic [1:0] a);
        return {a, 11'd0};
    endfunction
    function automatic int sat(input int c, input int w);
        return c > (1 << w) - 1 ? (1 << w) - 1 : c;
    endfunction
    function automatic logic [12:0] dec_vec(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
        bit cond, tk;
        cond = (m & s) != 4'd0;
        tk = (op == 4 || op == 5) ? cond : (op == 6 || op == 7) ? !cond : 1'b0;
        return ao(2'b10) | (op == 3 ? RB : 13'h0) | (tk ? (PW | PS | ((op == 4 || op == 6) ? BS : 13'h0)) : 13'h0);
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic step(input logic [12:0] e, input string nm);
        @(negedge clk);
        chk({nm, "_out16"}, {19'd0, v16}, {19'd0, e});
        chk({nm, "_out4"}, {19'd0, v4}, {19'd0, e});
        chk({nm, "_ret16"}, {16'd0, r16}, sat(cnt, 16));
        chk({nm, "_ret4"}, {28'd0, r4}, sat(cnt, 4));
        nst++;
    endtask
    task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
        nst = 0;
        step(ao(2'b10) | IR | PW, "fetch");
        opcode = op; mm = m; stat = s;
        step(dec_vec(op, m, s), "decode");
        last_dec = v16;
        if (op == 1) begin
            step(ao({1'b0, m[3]}), "alu_exec");
            last_exec = v16;
            step(ao({1'b0, m[3]}) | RF, "alu_wb");
        end else if (op == 2) begin
            step(ao(2'b11), "lod_exec");
            step(ao(2'b11) | MS, "lod_mem");
            step(ao(2'b11) | RF | WB | MS, "lod_wb");
        end else if (op == 3) begin
            step(ao(2'b11) | RB, "str_exec");
            step(ao(2'b11) | MS | DW | RB, "str_mem");
        end
        if (op != 15) cnt++;
        last_cyc = nst;
    endtask
    task automatic do_reset();
        rst_f = 1'b0;
        #1;
        chk("rst_async_out", {19'd0, v16}, 32'h1008);
        chk("rst_async_ret", {16'd0, r16}, 32'd0);
        cnt = 0;
        step(ao(2'b10) | PR, "start0");
        rst_f = 1'b1;
        step(ao(2'b10), "start1");
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        @(negedge clk);
        do_reset();
        run_instr(4'd1, 4'd0, 4'd0);
        chk("alu_reg_exec", {19'd0, last_exec}, 32'h0000);
        chk("alu_lat", last_cyc, 4);
        run_instr(4'd1, 4'd8, 4'd0);
        chk("alu_imm_exec", {19'd0, last_exec}, 32'h0800);
        run_instr(4'd2, 4'd3, 4'd0);
        chk("lod_lat", last_cyc, 5);
        run_instr(4'd3, 4'd0, 4'd0);
        chk("str_lat", last_cyc, 4);
        chk("str_dec", {19'd0, last_dec}, 32'h1100);
        run_instr(4'd4, 4'b0001, 4'b0001);
        chk("bra_taken", {19'd0, last_dec}, 32'h1070);
        chk("br_lat", last_cyc, 2);
        run_instr(4'd4, 4'b0001, 4'b0000);
        chk("bra_not", {19'd0, last_dec}, 32'h1000);
        run_instr(4'd7, 4'b1000, 4'b0000);
        chk("bnr_taken", {19'd0, last_dec}, 32'h1060);
        repeat (20) run_instr(4'd0, 4'($urandom), 4'($urandom));
        chk("nop_lat", last_cyc, 2);
        step(ao(2'b10) | IR | PW, "fetch_sat");
        chk("sat_ret4", {28'd0, r4}, 32'd15);
        chk("ret16_27", {16'd0, r16}, 32'd27);
        nst = 0;
        step(dec_vec(opcode, mm, stat), "decode_sat");
        cnt++;
        repeat (120) run_instr(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom));
        run_instr(4'd15, 4'($urandom), 4'($urandom));
        repeat (12) step(ao(2'b10) | HL, "halt");
        do_reset();
        step(ao(2'b10) | IR | PW, "fetch_lod");
        opcode = 4'd2; mm = 4'd0; stat = 4'd0;
        step(dec_vec(4'd2, 4'd0, 4'd0), "decode_lod");
        step(ao(2'b11), "lod_exec_rst");
        do_reset();
        repeat (30) run_instr(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sisc_ctrl.md
Name: sisc_ctrl

Overview:
Multicycle control unit for the sisc processor. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU's alu_op override, the register file, the PC and the data memory controls. It also evaluates branch conditions against the status register and counts retired instructions.

Parameters:
CNT_W, 16, width of the retired-instruction counter (saturating)

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  asynchronous active-low reset
opcode  in  4  IR[31:28]
mm  in  4  IR[27:24]: mode/branch mask; mm[3]=1 selects immediate operand for ALU_OP
stat  in  4  status register {C,V,N,Z}
alu_op  out  2  ALU override; bit1=1 suppresses status update, bit0=1 selects imm operand
rf_we  out  1  register file write enable
wb_sel  out  1  0 = ALU result, 1 = memory data
rb_sel  out  1  1 = read Rd on port B (store data)
ir_load  out  1  instruction register load
pc_write  out  1  PC load enable
pc_sel  out  1  0 = PC+1, 1 = branch target
br_sel  out  1  1 = absolute target (imm), 0 = PC-relative
pc_rst  out  1  PC clear
mm_sel  out  1  1 = memory address from ALU result
dm_we  out  1  data memory write enable
halted  out  1  high in HALT state
retired  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: NOP=0, ALU_OP=1, LOD=2, STR=3, BRA=4, BRR=5, BNE=6, BNR=7, HLT=15.
- Opcodes 8-14 behave exactly as NOP.
- State register is 3 bits. States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- Outputs are combinational functions of the registered state and opcode/mm/stat.
- Default for every output is 0, except alu_op, which defaults to 2'b10 so status never latches outside ALU execution.
- rst_f low, asserted asynchronously at any time, including mid-instruction:
  - state goes to START0 and retired goes to 0 immediately;
  - outputs take START0 values: pc_rst=1, alu_op=2'b10, all others 0.
- START0 -> START1: pc_rst=1.
- START1 -> FETCH: pc_rst=0.
- FETCH -> DECODE: ir_load=1, pc_write=1, pc_sel=0.
- DECODE:
  - Branch taken condition: BRA/BRR take when (mm & stat) != 0; BNE/BNR take when (mm & stat) == 0.
  - If the branch is taken: pc_write=1, pc_sel=1; br_sel=1 for BRA/BNE, 0 for BRR/BNR.
  - STR: rb_sel=1.
  - HLT -> HALT.
  - NOP, undefined opcodes and all branches (taken or not) -> FETCH, retiring the instruction.
  - ALU_OP, LOD, STR -> EXECUTE.
- EXECUTE:
  - ALU_OP: alu_op={1'b0, mm[3]}; -> WRITEBACK.
  - LOD: alu_op=2'b11 (address = Rs + sign-extended imm, no status update); -> MEM.
  - STR: alu_op=2'b11, rb_sel=1; -> MEM.
- MEM:
  - alu_op=2'b11, mm_sel=1.
  - LOD -> WRITEBACK.
  - STR: dm_we=1, rb_sel=1; -> FETCH (retire).
- WRITEBACK:
  - rf_we=1, with one rf_we pulse per instruction.
  - LOD: wb_sel=1, mm_sel=1, alu_op=2'b11.
  - ALU_OP: wb_sel=0, alu_op held at its EXECUTE value; the status re-latch is idempotent.
  - -> FETCH (retire).
- HALT: halted=1, all enables 0, alu_op=2'b10. Remains in HALT until reset.
- Latency in cycles, FETCH through retire:
  - NOP/branch = 2
  - STR = 4
  - ALU_OP = 4
  - LOD = 5
- Retire: increments retired by 1 on the clock edge of a transition into FETCH from DECODE, MEM or WRITEBACK. START1->FETCH does not count.
- retired saturates at 2^CNT_W-1 and never wraps.
- dm_we and rf_we are never asserted in the same cycle. pc_write is asserted only in FETCH and DECODE.

Decomposition:
- Package sisc_pkg holds opcode constants, the state encoding constants, and the ALU_OP_NOSTAT (2'b10) and ALU_OP_ADDR (2'b11) constants.
- One sub-module is natural: sisc_br_eval (opcode, mm, stat -> taken, br_sel), purely combinational.
- State register, next-state logic, output decode and the counter live in sisc_ctrl.

Test Plan:
- Reset: hold rst_f=0, release.
  - Expect START0 with pc_rst=1 and alu_op=2'b10, then START1, then FETCH with ir_load=1 and pc_write=1.
  - Expect retired=0.
- ALU reg/imm: opcode=1, mm=0 -> EXECUTE alu_op=2'b00, WRITEBACK rf_we=1, wb_sel=0. With mm=8 -> alu_op=2'b01. Each retires in 4 cycles, retired+=1.
- Load/store:
  - LOD: EXECUTE/MEM alu_op=2'b11, mm_sel=1 in MEM, WRITEBACK rf_we=1 with wb_sel=1; 5 cycles.
  - STR: dm_we=1 only in MEM, rb_sel=1 in DECODE..MEM, rf_we never 1.
- Branches, each returning to FETCH after DECODE:
  - BRA, mm=4'b0001, stat=4'b0001 -> DECODE pc_write=1, pc_sel=1, br_sel=1.
  - Same with stat=0 -> pc_write=0.
  - BNR, mm=4'b1000, stat=0 -> pc_sel=1, br_sel=0.
- HLT -> halted=1 indefinitely, retired frozen. Async rst_f pulse mid-EXECUTE of LOD -> immediate START0, retired=0, no rf_we pulse.
- Saturation: CNT_W=4, run 20 NOPs -> retired stops at 15.
